// File: rtl/shift_add_mul.sv
// Multi-cycle shift-and-add multiplier: one multiplier bit per RUN cycle through a
// single shared adder, producing the low WIDTH bits of a*b with valid/ready handshakes.

module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum
);
  // Carry-in 0, carry-out dropped: sums wrap modulo 2^WIDTH.
  assign sum = x + y;
endmodule

module shift_add_mul #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned LAST_BIT = WIDTH - 1;

  state_t           state;
  state_t           state_d;
  logic             accept;
  logic             step;
  logic             finish;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic [CNT_W-1:0] cnt;

  assign addend = mplier[0] ? mcand : '0;

  adder #(.WIDTH(WIDTH)) u_adder (
    .x   (acc),
    .y   (addend),
    .sum (sum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and datapath control; flush overrides every other request.
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if ((mplier >> 1) == '0 || cnt == CNT_W'(LAST_BIT)) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs registered from the next state so they track the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d == RUN);
      out_valid <= (state_d == DONE);
    end
  end

  // Operand capture and one shift-add step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
    end else if (step) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result latches the final accumulator value on DONE entry and holds it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      p <= '0;
    else if (finish) p <= sum;
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed and randomised checks of shift_add_mul: products, RUN cycle counts,
// backpressure, flush and asynchronous reset.

module tb_shift_add_mul;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] p;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  shift_add_mul #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (op_a),
    .b         (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int run_cycles(input logic [WIDTH-1:0] mul);
    int n;
    n = 1;
    for (int i = 0; i < WIDTH; i++) if (mul[i]) n = i + 1;
    return n;
  endfunction

  // Called at the first negedge after acceptance; counts RUN cycles until out_valid.
  task automatic wait_done(input string tag, input logic [31:0] exp_p, input int exp_cyc);
    int n;
    int guard;
    n = 0;
    guard = 0;
    while (!out_valid && guard < 200) begin
      if (busy) n++;
      guard++;
      @(negedge clk);
    end
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " run cycles"}, 32'(n), 32'(exp_cyc));
    check({tag, " p"}, p, exp_p);
  endtask

  task automatic consume(input int stall);
    for (int i = 0; i < stall; i++) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] exp_p, input int exp_cyc, input int stall);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    op_a     = xa;
    op_b     = xb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = 32'h5A5A_5A5A;
    op_b     = 32'hA5A5_A5A5;
    wait_done(tag, exp_p, exp_cyc);
    consume(stall);
    check({tag, " idle after consume"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset p", p, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("basic", 32'd7, 32'd6, 32'd42, 3, 0);
    do_op("b zero", 32'hDEAD_BEEF, 32'd0, 32'd0, 1, 0);
    do_op("b one", 32'h0000_1234, 32'd1, 32'h0000_1234, 1, 0);
    do_op("all ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, 0);
    do_op("msb wrap", 32'h8000_0000, 32'd2, 32'd0, 2, 0);
    do_op("neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 3, 0);

    // Backpressure: result held while a second operand waits upstream.
    op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("bp", 32'd12, 3);
    op_a = 32'd5; op_b = 32'd5; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp hold out_valid", 32'(out_valid), 32'd1);
      check("bp hold p", p, 32'd12);
      check("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp second accepted", 32'(busy), 32'd1);
    wait_done("bp second", 32'd25, 3);
    consume(0);

    // Flush in RUN cycle 2.
    op_a = 32'd9; op_b = 32'hFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("flush run1 busy", 32'(busy), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush to idle", 32'(in_ready), 32'd1);
    check("flush busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("flush no out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    do_op("after flush", 32'd2, 32'd3, 32'd6, 2, 0);

    // Flush beats in_valid in IDLE.
    op_a = 32'd11; op_b = 32'd11; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("idle flush no accept", 32'(busy), 32'd0);
    check("idle flush in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset between clock edges in the middle of RUN.
    op_a = 32'hFFFF; op_b = 32'hFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst p", p, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("after reset", 32'd10, 32'd10, 32'd100, 4, 0);

    // Random operands with random consumer stalls.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      case (i % 4)
        1: rb = rb >> $urandom_range(31, 0);
        2: rb = rb & 32'h0000_00FF;
        default: ;
      endcase
      do_op("random", ra, rb, ra * rb, run_cycles(rb), $urandom_range(3, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
